// File: rtl/seg7_pkg.sv
// Shared types and helpers for the 7-segment scan display blocks.
package seg7_pkg;

    localparam int NIBBLE_W   = 4;
    // Widest display the blanking helper handles; instantiations stay at or below this.
    localparam int MAX_DIGITS = 16;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    // Leading-zero blank vector: bit k is set when k >= 1 and digits k..n-1 of
    // value are all zero. Digit 0 is never blanked so a zero value still shows "0".
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [NIBBLE_W*MAX_DIGITS-1:0] value,
        input int                             n
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  upper_zero;
        mask       = '0;
        upper_zero = 1'b1;
        for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
            if (k < n) begin
                upper_zero = upper_zero && (value[k*NIBBLE_W +: NIBBLE_W] == '0);
                mask[k]    = (k != 0) && upper_zero;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg7_refresh_div.sv
// Free-running refresh divider: step pulses once every REFRESH_DIV clocks.
module seg7_refresh_div #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic step
);
    localparam int CNT_W = $clog2(REFRESH_DIV + 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    assign step = (div_cnt_q == CNT_W'(REFRESH_DIV - 1));

    // Count up to the terminal value, then restart from zero.
    always_comb begin
        div_cnt_d = div_cnt_q + CNT_W'(1);
        if (step) begin
            div_cnt_d = '0;
        end
    end

    // Divider counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed N-digit 7-segment scan driver. A new value is held in a pending
// buffer and only committed to the displayed value at a frame boundary, so one
// frame never mixes old and new digits.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] in_value,
    input  logic                           blank_lz,
    output logic [NIBBLE_W-1:0]            nib_out,
    output logic [NUM_DIGITS-1:0]          dig_en_n,
    output logic                           frame_tick
);
    localparam int              IDX_W    = $clog2(NUM_DIGITS);
    localparam int              VAL_W    = NIBBLE_W * NUM_DIGITS;
    localparam int              EXT_W    = NIBBLE_W * MAX_DIGITS;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic                  step;
    logic                  wrap;
    logic                  accept;
    logic                  commit;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_d;
    logic [VAL_W-1:0]      pending_q;
    logic [VAL_W-1:0]      pending_d;
    logic [VAL_W-1:0]      shown_q;
    logic [VAL_W-1:0]      shown_d;
    logic                  pending_full_q;
    logic                  pending_full_d;
    logic                  in_ready_q;
    logic                  refresh_q;
    logic                  frame_tick_q;
    nibble_t               nib_q;
    nibble_t               nib_d;
    nibble_t               nib_sel;
    logic [NUM_DIGITS-1:0] dig_en_n_q;
    logic [NUM_DIGITS-1:0] dig_en_n_d;
    logic [NUM_DIGITS-1:0] dig_sel;
    logic [NUM_DIGITS-1:0] blank_vec;
    logic                  sel_blank;

    seg7_refresh_div #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_refresh_div (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (step)
    );

    // Scan index advance, input handshake and frame-boundary commit.
    // Commit needs a full buffer and accept needs an empty one, so they never collide;
    // a value accepted on the wrap edge waits for the next wrap.
    always_comb begin
        wrap           = step && (idx_q == IDX_LAST);
        idx_d          = idx_q;
        if (step) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
        accept         = in_valid && in_ready_q;
        commit         = wrap && pending_full_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        shown_d        = shown_q;
        if (commit) begin
            shown_d        = pending_q;
            pending_full_d = 1'b0;
        end else if (accept) begin
            pending_d      = in_value;
            pending_full_d = 1'b1;
        end
    end

    // Output selection for the upcoming digit; reloaded on a step and on the edge
    // after a commit so a new value shows up within one clock of the wrap.
    always_comb begin
        blank_vec = NUM_DIGITS'(lz_mask(EXT_W'(shown_q), NUM_DIGITS));
        nib_sel   = '0;
        sel_blank = 1'b0;
        dig_sel   = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                nib_sel    = shown_q[k*NIBBLE_W +: NIBBLE_W];
                sel_blank  = blank_lz && blank_vec[k];
                dig_sel[k] = 1'b0;
            end
        end
        if (sel_blank) begin
            dig_sel = '1;
        end
        nib_d      = nib_q;
        dig_en_n_d = dig_en_n_q;
        if (step || refresh_q) begin
            nib_d      = nib_sel;
            dig_en_n_d = dig_sel;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q          <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            shown_q        <= '0;
            in_ready_q     <= 1'b1;
            refresh_q      <= 1'b0;
            frame_tick_q   <= 1'b0;
            nib_q          <= '0;
            dig_en_n_q     <= '1;
        end else begin
            idx_q          <= idx_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            shown_q        <= shown_d;
            in_ready_q     <= ~pending_full_d;
            refresh_q      <= commit;
            frame_tick_q   <= wrap;
            nib_q          <= nib_d;
            dig_en_n_q     <= dig_en_n_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign nib_out    = nib_q;
    assign dig_en_n   = dig_en_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: 4 digits, 4 clocks per digit, plus a 1-clock-per-digit build.
module tb_seg7_scan_mux;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int FR = N * R;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_value = '0;
    logic        blank_lz = 1'b0;
    logic        in_ready;
    logic [3:0]  nib_out;
    logic [3:0]  dig_en_n;
    logic        frame_tick;

    logic        in_valid1 = 1'b0;
    logic [15:0] in_value1 = '0;
    logic        blank_lz1 = 1'b0;
    logic        in_ready1;
    logic [3:0]  nib_out1;
    logic [3:0]  dig_en_n1;
    logic        frame_tick1;

    int n_cmp = 0;
    int n_err = 0;

    seg7_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .blank_lz(blank_lz), .nib_out(nib_out),
        .dig_en_n(dig_en_n), .frame_tick(frame_tick)
    );

    seg7_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_value(in_value1), .blank_lz(blank_lz1), .nib_out(nib_out1),
        .dig_en_n(dig_en_n1), .frame_tick(frame_tick1)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // t = clock edges since reset release. Digit on display after edge t is
    // (t/R)%N, a new digit starts when t%R==0 and a frame starts when t%FR==0.
    int          t;
    logic [15:0] m_shown, m_pend, m_old;
    bit          m_full, m_refresh, m_acc, m_step, m_wrap, m_commit;
    int          m_d;
    logic [3:0]  m_nib, m_den;
    logic        m_tick, m_rdy;

    // Expected {nib, dig_en_n} for digit d of val: blanked when it lies above
    // the most significant nonzero digit.
    function automatic logic [7:0] disp(input logic [15:0] val, input int d, input logic blank);
        logic [3:0] nib;
        logic [3:0] den;
        int         h;
        h = 0;
        for (int i = 0; i < N; i++) begin
            if (((val >> (4 * i)) & 16'hF) != 16'h0) h = i;
        end
        nib = 4'((val >> (4 * d)) & 16'hF);
        den = (blank && d > h) ? 4'hF : ~(4'(1) << d);
        return {nib, den};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0; m_shown = '0; m_pend = '0; m_full = 0; m_refresh = 0; m_acc = 0;
            m_nib = '0; m_den = '1; m_tick = 0; m_rdy = 1;
        end else begin
            t        = t + 1;
            m_old    = m_shown;
            m_step   = (t % R) == 0;
            m_d      = (t / R) % N;
            m_wrap   = m_step && (m_d == 0);
            m_acc    = in_valid && m_rdy;
            m_commit = m_wrap && m_full;
            if (m_commit) begin
                m_shown = m_pend; m_full = 0;
            end else if (m_acc) begin
                m_pend = in_value; m_full = 1;
            end
            if (m_step) {m_nib, m_den} = disp(m_old, m_d, blank_lz);
            else if (m_refresh) {m_nib, m_den} = disp(m_shown, m_d, blank_lz);
            m_refresh = m_commit;
            m_tick    = m_wrap;
            m_rdy     = !m_full;
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({nib_out, dig_en_n, frame_tick, in_ready} !== 10'b0000_1111_0_1) begin
            n_err++;
            $display("FAIL reset_values: nib/den/tick/rdy got %h/%b/%b/%b want 0/1111/0/1", nib_out, dig_en_n, frame_tick, in_ready);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2 * FR; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({nib_out, dig_en_n, frame_tick, in_ready} !== {m_nib, m_den, m_tick, m_rdy}) begin
                n_err++;
                $display("FAIL idle_scan t=%0d: nib/den/tick/rdy got %h/%b/%b/%b want %h/%b/%b/%b", t, nib_out, dig_en_n, frame_tick, in_ready, m_nib, m_den, m_tick, m_rdy);
            end
        end
    endtask

    task automatic test_accept();
        int w;
        w = -1;
        for (int c = 0; c < FR && (t % FR) != 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({nib_out, dig_en_n, frame_tick, in_ready} !== {m_nib, m_den, m_tick, m_rdy}) begin
                n_err++;
                $display("FAIL accept_align t=%0d: nib/den/tick/rdy got %h/%b/%b/%b want %h/%b/%b/%b", t, nib_out, dig_en_n, frame_tick, in_ready, m_nib, m_den, m_tick, m_rdy);
            end
        end
        in_value = 16'h12AF; in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m_acc && in_valid) begin
                in_valid = 1'b0;
                w = (t / FR + 1) * FR;
            end
            n_cmp++;
            if ({nib_out, dig_en_n, frame_tick, in_ready} !== {m_nib, m_den, m_tick, m_rdy}) begin
                n_err++;
                $display("FAIL accept t=%0d: nib/den/tick/rdy got %h/%b/%b/%b want %h/%b/%b/%b", t, nib_out, dig_en_n, frame_tick, in_ready, m_nib, m_den, m_tick, m_rdy);
            end
            for (int d = 0; d < N; d++) begin
                if (w > 0 && t == w + 2 + R * d) begin
                    n_cmp++;
                    if ({nib_out, dig_en_n} !== {4'((16'h12AF >> (4 * d)) & 16'hF), ~(4'(1) << d)}) begin
                        n_err++;
                        $display("FAIL accept_digit%0d: nib/den got %h/%b want %h/%b", d, nib_out, dig_en_n, 4'((16'h12AF >> (4 * d)) & 16'hF), ~(4'(1) << d));
                    end
                end
            end
        end
    endtask

    task automatic test_held_valid();
        int t_acc;
        t_acc = -1;
        in_value = 16'h0A0B; in_valid = 1'b1;
        for (int c = 0; c < 120 && in_valid; c++) begin
            @(negedge clk);
            if (m_acc) begin
                if (in_value == 16'h0A0B) in_value = 16'h5555;
                else begin in_valid = 1'b0; t_acc = t; end
            end
            n_cmp++;
            if ({nib_out, dig_en_n, frame_tick, in_ready} !== {m_nib, m_den, m_tick, m_rdy}) begin
                n_err++;
                $display("FAIL held_valid t=%0d: nib/den/tick/rdy got %h/%b/%b/%b want %h/%b/%b/%b", t, nib_out, dig_en_n, frame_tick, in_ready, m_nib, m_den, m_tick, m_rdy);
            end
        end
        n_cmp++;
        if (t_acc < 0 || (t_acc % FR) != 1) begin
            n_err++;
            $display("FAIL held_accept_edge: accepted at edge %0d (frame pos %0d) want frame pos 1", t_acc, t_acc % FR);
            in_valid = 1'b0;
        end
        for (int c = 0; c < 2 * FR; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({nib_out, dig_en_n, frame_tick, in_ready} !== {m_nib, m_den, m_tick, m_rdy}) begin
                n_err++;
                $display("FAIL held_show t=%0d: nib/den/tick/rdy got %h/%b/%b/%b want %h/%b/%b/%b", t, nib_out, dig_en_n, frame_tick, in_ready, m_nib, m_den, m_tick, m_rdy);
            end
        end
    endtask

    task automatic test_blank();
        logic [15:0] vals [2];
        vals[0] = 16'h0070; vals[1] = 16'h0000;
        blank_lz = 1'b1;
        for (int v = 0; v < 2; v++) begin
            in_value = vals[v]; in_valid = 1'b1;
            for (int c = 0; c < 70; c++) begin
                @(negedge clk);
                if (m_acc) in_valid = 1'b0;
                n_cmp++;
                if ({nib_out, dig_en_n, frame_tick, in_ready} !== {m_nib, m_den, m_tick, m_rdy}) begin
                    n_err++;
                    $display("FAIL blank_%h t=%0d: nib/den/tick/rdy got %h/%b/%b/%b want %h/%b/%b/%b", vals[v], t, nib_out, dig_en_n, frame_tick, in_ready, m_nib, m_den, m_tick, m_rdy);
                end
            end
            n_cmp++;
            if (in_valid) begin
                n_err++;
                $display("FAIL blank_accept_timeout: value %h never accepted", vals[v]);
                in_valid = 1'b0;
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_wrap_accept();
        int w;
        w = -1;
        for (int c = 0; c < 3 * FR; c++) begin
            if (m_rdy && (t % FR) == FR - 1) break;
            @(negedge clk);
            n_cmp++;
            if ({nib_out, dig_en_n, frame_tick, in_ready} !== {m_nib, m_den, m_tick, m_rdy}) begin
                n_err++;
                $display("FAIL wrap_align t=%0d: nib/den/tick/rdy got %h/%b/%b/%b want %h/%b/%b/%b", t, nib_out, dig_en_n, frame_tick, in_ready, m_nib, m_den, m_tick, m_rdy);
            end
        end
        in_value = 16'hBEEF; in_valid = 1'b1;
        for (int c = 0; c < 3 * FR; c++) begin
            @(negedge clk);
            if (m_acc && in_valid) begin
                in_valid = 1'b0;
                w = t;
                n_cmp++;
                if ((t % FR) != 0) begin
                    n_err++;
                    $display("FAIL wrap_accept_edge: accepted at frame pos %0d want 0", t % FR);
                end
            end
            n_cmp++;
            if ({nib_out, dig_en_n, frame_tick, in_ready} !== {m_nib, m_den, m_tick, m_rdy}) begin
                n_err++;
                $display("FAIL wrap_accept t=%0d: nib/den/tick/rdy got %h/%b/%b/%b want %h/%b/%b/%b", t, nib_out, dig_en_n, frame_tick, in_ready, m_nib, m_den, m_tick, m_rdy);
            end
            if (w >= 0 && t == w + 2) begin
                n_cmp++;
                if (nib_out !== 4'h0) begin
                    n_err++;
                    $display("FAIL wrap_not_this_frame: nib got %h want 0", nib_out);
                end
            end
            if (w >= 0 && t == w + FR + 2) begin
                n_cmp++;
                if ({nib_out, dig_en_n} !== {4'hF, 4'b1110}) begin
                    n_err++;
                    $display("FAIL wrap_next_frame: nib/den got %h/%b want f/1110", nib_out, dig_en_n);
                end
            end
        end
        n_cmp++;
        if (w < 0) begin
            n_err++;
            $display("FAIL wrap_accept_timeout: value never accepted");
            in_valid = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (m_acc) in_valid = 1'b0;
            if (!in_valid && $urandom_range(0, 5) == 0) begin
                in_value = 16'($urandom) >> (4 * $urandom_range(0, 4));
                in_valid = 1'b1;
            end
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            n_cmp++;
            if ({nib_out, dig_en_n, frame_tick, in_ready} !== {m_nib, m_den, m_tick, m_rdy}) begin
                n_err++;
                $display("FAIL random t=%0d: nib/den/tick/rdy got %h/%b/%b/%b want %h/%b/%b/%b", t, nib_out, dig_en_n, frame_tick, in_ready, m_nib, m_den, m_tick, m_rdy);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 5 * FR; c++) begin
            if (m_rdy && !in_valid && (t % FR) == 2) break;
            @(negedge clk);
            if (m_acc) in_valid = 1'b0;
            n_cmp++;
            if ({nib_out, dig_en_n, frame_tick, in_ready} !== {m_nib, m_den, m_tick, m_rdy}) begin
                n_err++;
                $display("FAIL rst_align t=%0d: nib/den/tick/rdy got %h/%b/%b/%b want %h/%b/%b/%b", t, nib_out, dig_en_n, frame_tick, in_ready, m_nib, m_den, m_tick, m_rdy);
            end
        end
        blank_lz = 1'b0;
        in_value = 16'h3C3C; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (m_acc) in_valid = 1'b0;
            n_cmp++;
            if ({nib_out, dig_en_n, frame_tick, in_ready} !== {m_nib, m_den, m_tick, m_rdy}) begin
                n_err++;
                $display("FAIL rst_fill t=%0d: nib/den/tick/rdy got %h/%b/%b/%b want %h/%b/%b/%b", t, nib_out, dig_en_n, frame_tick, in_ready, m_nib, m_den, m_tick, m_rdy);
            end
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({nib_out, dig_en_n, frame_tick, in_ready, nib_out1, dig_en_n1, frame_tick1, in_ready1} !== 20'b0000_1111_0_1_0000_1111_0_1) begin
            n_err++;
            $display("FAIL rst_async: nib/den/tick/rdy got %h/%b/%b/%b fast %h/%b/%b/%b want 0/1111/0/1", nib_out, dig_en_n, frame_tick, in_ready, nib_out1, dig_en_n1, frame_tick1, in_ready1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3 * FR; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({nib_out, dig_en_n, frame_tick, in_ready} !== {m_nib, m_den, m_tick, m_rdy}) begin
                n_err++;
                $display("FAIL rst_after t=%0d: nib/den/tick/rdy got %h/%b/%b/%b want %h/%b/%b/%b", t, nib_out, dig_en_n, frame_tick, in_ready, m_nib, m_den, m_tick, m_rdy);
            end
            n_cmp++;
            if ({nib_out1, dig_en_n1, frame_tick1, in_ready1} !== {4'h0, ~(4'(1) << (t % N)), (t % N) == 0, 1'b1}) begin
                n_err++;
                $display("FAIL fast_scan t=%0d: nib/den/tick/rdy got %h/%b/%b/%b want 0/%b/%b/1", t, nib_out1, dig_en_n1, frame_tick1, in_ready1, ~(4'(1) << (t % N)), (t % N) == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_accept();
        test_held_valid();
        test_blank();
        test_wrap_accept();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
